comp_serial_mag: RTL

- Parametrised multi-bit magnitude comparator; successor to the 1-bit equality comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock. Reports one-hot eq/gt/lt.
- Trades latency for area. Ready/valid handshakes on input and output, so it sits between datapath stages with backpressure.

---
 rtl/comp_serial_mag.sv | 132 +++++++++++++
 1 files changed

// File: rtl/comp_serial_mag.sv
// Serial MSB-first magnitude comparator, DIGIT bits per clock, one-hot eq/gt/lt.
// Define COMP_EARLY_EXIT_EN to finish on the first differing digit.
module comp_serial_mag #(
    parameter int WIDTH  = 16,
    parameter int DIGIT  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK =
        SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {D_UND, D_LT, D_GT} dec_t;

    state_t           state_q, state_d;
    dec_t             dec_q, dec_d, dec_step;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [DIGIT-1:0] da, db;
    logic             finish;

    assign da = a_q[WIDTH-1 -: DIGIT];
    assign db = b_q[WIDTH-1 -: DIGIT];

    // The first unequal digit decides; later digits cannot change it.
    always_comb begin
        dec_step = dec_q;
        if (dec_q == D_UND) begin
            if (da > db)
                dec_step = D_GT;
            else if (da < db)
                dec_step = D_LT;
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bit maps two's complement onto unsigned order
                    a_d     = a ^ MSB_MASK;
                    b_d     = b ^ MSB_MASK;
                    dec_d   = D_UND;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q << DIGIT;
                b_d    = b_q << DIGIT;
                cnt_d  = cnt_q + CW'(1);
                dec_d  = dec_step;
                finish = (cnt_q == LAST);
`ifdef COMP_EARLY_EXIT_EN
                if (dec_q == D_UND && dec_step != D_UND)
                    finish = 1'b1;
`endif
                if (finish) begin
                    state_d = DONE;
                    eq_d    = (dec_step == D_UND);
                    gt_d    = (dec_step == D_GT);
                    lt_d    = (dec_step == D_LT);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dec_q   <= D_UND;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;

endmodule
